// File: rtl/alu_pkt_ctrl.sv
// Packet sequencer between the UART byte stream and the ALU datapath: parses framed
// commands, runs echo / add-reduce / multiply-reduce and streams results back little-endian.
module alu_pkt_ctrl #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hAD,
  parameter logic [7:0] OP_MUL  = 8'h88
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_valid_o,
  input  logic        mul_ready_i,
  input  logic [31:0] mul_result_i,
  input  logic        mul_result_valid_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO,
    S_OPND, S_MUL_REQ, S_MUL_WAIT, S_SEND, S_DRAIN
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  opcode_reg, opcode_next;
  logic [7:0]  len_lo_reg, len_lo_next;
  logic [15:0] remaining_reg, remaining_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] opnd_reg, opnd_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic        first_reg, first_next;
  logic        err_reg, err_next;

  logic        rx_fire, tx_fire;
  logic [15:0] len_full, len_rem;
  logic [31:0] opnd_full;
  logic        op_known, op_arith;
  logic [7:0]  acc_byte [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_acc_byte
    assign acc_byte[gi] = acc_reg[8*gi +: 8];
  end

  assign rx_fire   = rx_valid_i & rx_ready_o;
  assign tx_fire   = tx_valid_o & tx_ready_i;
  assign len_full  = {rx_data_i, len_lo_reg};
  assign len_rem   = len_full - 16'd4;
  // Operand bytes arrive LSB first, so shift each new byte in at the top.
  assign opnd_full = {rx_data_i, opnd_reg[31:8]};
  assign op_arith  = (opcode_reg == OP_ADD) || (opcode_reg == OP_MUL);
  assign op_known  = op_arith || (opcode_reg == OP_ECHO);

  assign busy_o = (state_reg != S_IDLE);
  assign err_o  = err_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      opcode_reg    <= '0;
      len_lo_reg    <= '0;
      remaining_reg <= '0;
      acc_reg       <= '0;
      opnd_reg      <= '0;
      byte_cnt_reg  <= '0;
      first_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      opcode_reg    <= opcode_next;
      len_lo_reg    <= len_lo_next;
      remaining_reg <= remaining_next;
      acc_reg       <= acc_next;
      opnd_reg      <= opnd_next;
      byte_cnt_reg  <= byte_cnt_next;
      first_reg     <= first_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    opcode_next    = opcode_reg;
    len_lo_next    = len_lo_reg;
    remaining_next = remaining_reg;
    acc_next       = acc_reg;
    opnd_next      = opnd_reg;
    byte_cnt_next  = byte_cnt_reg;
    first_next     = first_reg;
    err_next       = 1'b0;
    case (state_reg)
      S_IDLE: if (rx_fire) begin
        opcode_next = rx_data_i;
        state_next  = S_RSVD;
      end
      S_RSVD: if (rx_fire) state_next = S_LEN_LO;
      S_LEN_LO: if (rx_fire) begin
        len_lo_next = rx_data_i;
        state_next  = S_LEN_HI;
      end
      S_LEN_HI: if (rx_fire) begin
        remaining_next = len_rem;
        byte_cnt_next  = 2'd0;
        first_next     = 1'b1;
        if (len_full < 16'd4) begin
          err_next       = 1'b1;
          remaining_next = '0;
          state_next     = S_IDLE;
        end else if (!op_known) begin
          err_next   = 1'b1;
          state_next = (len_rem == 16'd0) ? S_IDLE : S_DRAIN;
        end else if (op_arith && (len_rem[1:0] != 2'd0)) begin
          err_next   = 1'b1;
          state_next = S_DRAIN;
        end else if (len_rem == 16'd0) begin
          if (opcode_reg == OP_ECHO) begin
            state_next = S_IDLE;
          end else begin
            // Empty reductions return the identity of the operation.
            acc_next   = (opcode_reg == OP_MUL) ? 32'd1 : 32'd0;
            state_next = S_SEND;
          end
        end else begin
          state_next = (opcode_reg == OP_ECHO) ? S_ECHO : S_OPND;
        end
      end
      S_ECHO: if (rx_fire) begin
        remaining_next = remaining_reg - 16'd1;
        if (remaining_reg == 16'd1) state_next = S_IDLE;
      end
      S_OPND: if (rx_fire) begin
        remaining_next = remaining_reg - 16'd1;
        opnd_next      = opnd_full;
        byte_cnt_next  = byte_cnt_reg + 2'd1;
        if (byte_cnt_reg == 2'd3) begin
          first_next = 1'b0;
          if (first_reg) acc_next = opnd_full;
          else if (opcode_reg == OP_ADD) acc_next = acc_reg + opnd_full;
          if (!first_reg && (opcode_reg == OP_MUL)) state_next = S_MUL_REQ;
          else if (remaining_reg == 16'd1) state_next = S_SEND;
        end
      end
      S_MUL_REQ: if (mul_ready_i) state_next = S_MUL_WAIT;
      S_MUL_WAIT: if (mul_result_valid_i) begin
        acc_next   = mul_result_i;
        state_next = (remaining_reg == 16'd0) ? S_SEND : S_OPND;
      end
      S_SEND: if (tx_fire) begin
        byte_cnt_next = byte_cnt_reg + 2'd1;
        if (byte_cnt_reg == 2'd3) state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (remaining_reg == 16'd0) begin
          state_next = S_IDLE;
        end else if (rx_fire) begin
          remaining_next = remaining_reg - 16'd1;
          if (remaining_reg == 16'd1) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are forced quiet while reset is held, whatever the state.
  always_comb begin
    rx_ready_o  = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'd0;
    mul_valid_o = 1'b0;
    mul_a_o     = 32'd0;
    mul_b_o     = 32'd0;
    if (rst) begin
      case (state_reg)
        S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPND: rx_ready_o = 1'b1;
        S_DRAIN: rx_ready_o = (remaining_reg != 16'd0);
        S_ECHO: begin
          tx_data_o  = rx_data_i;
          tx_valid_o = rx_valid_i;
          rx_ready_o = tx_ready_i;
        end
        S_MUL_REQ: begin
          mul_valid_o = 1'b1;
          mul_a_o     = acc_reg;
          mul_b_o     = opnd_reg;
        end
        S_SEND: begin
          tx_valid_o = 1'b1;
          tx_data_o  = acc_byte[byte_cnt_reg];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pkt_ctrl.sv
// Randomized bench for alu_pkt_ctrl: packets are turned into expected TX bytes, multiplier
// requests and error pulses by a packet-level model, then compared every cycle.
`timescale 1ns/1ps
module tb_alu_pkt_ctrl;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] mul_a_o, mul_b_o;
  logic        mul_valid_o;
  logic        mul_ready_i;
  logic [31:0] mul_result_i;
  logic        mul_result_valid_i;
  logic        busy_o;
  logic        err_o;

  alu_pkt_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_valid_o(mul_valid_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
    .mul_result_valid_i(mul_result_valid_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int err_exp = 0;
  int err_seen = 0;
  int mul_req_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [63:0] exp_mul[$];
  logic [7:0]  tx_log[$];
  bit tx_mode = 1'b0;
  bit mul_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Packet-level reference: what the controller must emit for one whole packet.
  task automatic model_packet(input byte_q_t pkt);
    int len, rem;
    logic [31:0] acc, v;
    len = int'({pkt[3], pkt[2]});
    if (len < 4) begin
      err_exp++;
      return;
    end
    rem = len - 4;
    if (pkt[0] != OP_ECHO && pkt[0] != OP_ADD && pkt[0] != OP_MUL) begin
      err_exp++;
      return;
    end
    if (pkt[0] != OP_ECHO && (rem % 4) != 0) begin
      err_exp++;
      return;
    end
    if (pkt[0] == OP_ECHO) begin
      for (int i = 4; i < len; i++) exp_tx.push_back(pkt[i]);
    end else begin
      acc = (pkt[0] == OP_ADD) ? 32'd0 : 32'd1;
      for (int k = 0; k < rem / 4; k++) begin
        v = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
        if (pkt[0] == OP_ADD) begin
          acc = acc + v;
        end else begin
          if (k > 0) exp_mul.push_back({acc, v});
          acc = acc * v;
        end
      end
      for (int i = 0; i < 4; i++) exp_tx.push_back(acc[8*i +: 8]);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_pkt(input byte_q_t pkt, input int gap_max);
    int g, t;
    bit done;
    model_packet(pkt);
    tx_log.delete();
    foreach (pkt[i]) begin
      g = int'($urandom_range(0, gap_max));
      repeat (g) begin
        rx_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = pkt[i];
      done = 1'b0;
      t = 0;
      while (!done) begin
        @(negedge clk);
        if (rx_ready_o) done = 1'b1;
        @(posedge clk); #1;
        t++;
        if (!done && t > 400) begin
          timeout_fail("rx_accept");
          rx_valid_i = 1'b0;
          return;
        end
      end
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    repeat (2) begin @(posedge clk); #1; end
    while (busy_o || exp_tx.size() != 0) begin
      @(posedge clk); #1;
      t++;
      if (t > 3000) begin
        timeout_fail({name, "_idle"});
        break;
      end
    end
    check({name, "_err_count"}, 32'(err_seen), 32'(err_exp));
    check({name, "_mul_left"}, 32'(exp_mul.size()), 32'd0);
  endtask

  task automatic check_log(input string name, input int n, input logic [31:0] word);
    logic [31:0] w;
    w = '0;
    check({name, "_tx_len"}, 32'(tx_log.size()), 32'(n));
    for (int i = 0; i < tx_log.size() && i < 4; i++) w[8*i +: 8] = tx_log[i];
    check({name, "_tx_data"}, w, word);
  endtask

  task automatic rand_pkt(output byte_q_t p);
    int kind, n, len;
    logic [7:0] op;
    p.delete();
    kind = int'($urandom_range(0, 9));
    case (kind)
      0, 1:    begin op = OP_ECHO; n = int'($urandom_range(0, 6)); end
      2, 3, 4: begin op = OP_ADD;  n = 4 * int'($urandom_range(0, 4)); end
      5, 6, 7: begin op = OP_MUL;  n = 4 * int'($urandom_range(0, 4)); end
      8: begin
        op = 8'($urandom_range(0, 255));
        if (op == OP_ECHO || op == OP_ADD || op == OP_MUL) op = 8'h55;
        n = int'($urandom_range(0, 5));
      end
      default: begin
        op = ($urandom_range(0, 1) != 0) ? OP_ADD : OP_MUL;
        n = 4 * int'($urandom_range(0, 2)) + int'($urandom_range(1, 3));
      end
    endcase
    len = n + 4;
    if (kind == 8 && $urandom_range(0, 2) == 0) begin
      len = int'($urandom_range(0, 3));
      n = 0;
    end
    p.push_back(op);
    p.push_back(8'($urandom()));
    p.push_back(8'(len));
    p.push_back(8'(len >> 8));
    for (int i = 0; i < n; i++) p.push_back(8'($urandom()));
  endtask

  // Multiplier and transmitter models; inputs change at posedge+1.
  initial begin : periph
    int dly;
    bit pend, acc_now;
    logic [31:0] prod, a_s, b_s;
    dly = 0; pend = 1'b0; prod = '0;
    mul_ready_i = 1'b0; mul_result_valid_i = 1'b0; mul_result_i = '0;
    tx_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      acc_now = mul_valid_o && mul_ready_i && rst;
      a_s = mul_a_o;
      b_s = mul_b_o;
      @(posedge clk); #1;
      mul_result_valid_i = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          mul_result_valid_i = 1'b1;
          mul_result_i = prod;
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (acc_now) begin
        pend = 1'b1;
        prod = a_s * b_s;
        dly = mul_force ? 5 : int'($urandom_range(0, 5));
      end
      mul_ready_i = mul_force ? 1'b1 : 1'($urandom_range(0, 1));
      tx_ready_i  = tx_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Per-cycle compare against the model queues and the handshake hold rules.
  initial begin : compare
    bit tx_wait, mul_wait;
    logic [7:0] tx_hold;
    logic [31:0] a_hold, b_hold;
    logic [63:0] m;
    tx_wait = 1'b0; mul_wait = 1'b0;
    tx_hold = '0; a_hold = '0; b_hold = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_tx.delete();
        exp_mul.delete();
        tx_wait = 1'b0;
        mul_wait = 1'b0;
      end else begin
        if (tx_wait) begin
          check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
          check("tx_hold_data", 32'(tx_data_o), 32'(tx_hold));
        end
        if (mul_wait) begin
          check("mul_hold_valid", 32'(mul_valid_o), 32'd1);
          check("mul_hold_a", mul_a_o, a_hold);
          check("mul_hold_b", mul_b_o, b_hold);
        end
        if (tx_valid_o && tx_ready_i) begin
          tx_log.push_back(tx_data_o);
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got %h, expected no byte at %0t", tx_data_o, $time);
          end else begin
            check("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
          end
        end
        if (mul_valid_o && mul_ready_i) begin
          mul_req_cnt++;
          if (exp_mul.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mul_unexpected: got a=%h b=%h, expected no request", mul_a_o, mul_b_o);
          end else begin
            m = exp_mul.pop_front();
            check("mul_a", mul_a_o, m[63:32]);
            check("mul_b", mul_b_o, m[31:0]);
          end
        end
        if (err_o) err_seen++;
        tx_wait  = tx_valid_o && !tx_ready_i;
        tx_hold  = tx_data_o;
        mul_wait = mul_valid_o && !mul_ready_i;
        a_hold   = mul_a_o;
        b_hold   = mul_b_o;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    byte_q_t pkt;
    int t, base;
    rst = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i = OP_ADD;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_rx_ready", 32'(rx_ready_o), 32'd0);
      check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      check("rst_mul_valid", 32'(mul_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("release_rx_ready", 32'(rx_ready_o), 32'd1);
    rx_valid_i = 1'b0;
    @(posedge clk); #1;

    tx_mode = 1'b1;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_pkt(pkt, 0);
    wait_idle("add_wrap");
    check_log("add_wrap", 4, 32'h0000_0000);

    base = mul_req_cnt;
    pkt = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 1);
    wait_idle("mul3");
    check("mul3_requests", 32'(mul_req_cnt - base), 32'd2);
    check_log("mul3", 4, 32'h0000_0069);

    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_pkt(pkt, 1);
    wait_idle("echo3");
    check_log("echo3", 3, 32'h0043_4241);

    pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
    send_pkt(pkt, 0);
    wait_idle("echo0");
    check_log("echo0", 0, 32'h0);

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt(pkt, 0);
    pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(pkt, 0);
    wait_idle("err_opcode");
    check_log("err_opcode_next", 4, 32'h4433_2211);

    pkt = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
    send_pkt(pkt, 0);
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h02, 8'h00, 8'h00, 8'h80};
    send_pkt(pkt, 0);
    wait_idle("err_len7");
    check_log("err_len7_next", 4, 32'h0000_0003);

    pkt = '{8'hAD, 8'h00, 8'h02, 8'h00};
    send_pkt(pkt, 0);
    pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_pkt(pkt, 0);
    wait_idle("err_len2");
    check_log("err_len2_next", 4, 32'h1234_5678);

    // Reset while the multiplier result is outstanding.
    mul_force = 1'b1;
    base = mul_req_cnt;
    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 0);
    t = 0;
    while (mul_req_cnt == base && t < 100) begin @(posedge clk); #1; t++; end
    check("mulwait_reached", 32'(mul_req_cnt - base), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mulwait_rst_busy", 32'(busy_o), 32'd0);
    check("mulwait_rst_mul_valid", 32'(mul_valid_o), 32'd0);
    check("mulwait_rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("mulwait_rst_err", 32'(err_o), 32'd0);
    tx_log.delete();
    repeat (10) begin @(posedge clk); #1; end
    check("late_result_busy", 32'(busy_o), 32'd0);
    check_log("late_result", 0, 32'h0);
    mul_force = 1'b0;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 0);
    wait_idle("after_mulrst");
    check_log("after_mulrst", 4, 32'h0000_0030);

    // Reset while the third result byte is being offered.
    tx_mode = 1'b0;
    pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(pkt, 0);
    t = 0;
    while (tx_log.size() < 2 && t < 100) begin @(posedge clk); #1; t++; end
    rst = 1'b0;
    @(negedge clk);
    check("send_rst_tx_valid_hold", 32'(tx_valid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("send_rst_busy", 32'(busy_o), 32'd0);
    check("send_rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check_log("send_rst", 2, 32'h0000_0201);
    @(posedge clk); #1;
    pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'hF0, 8'h0F, 8'hAA, 8'h55};
    send_pkt(pkt, 0);
    wait_idle("after_sendrst");
    check_log("after_sendrst", 4, 32'h55AA_0FF0);

    // Randomized back-to-back traffic with tx and multiplier stalls.
    tx_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rand_pkt(pkt);
      send_pkt(pkt, int'($urandom_range(0, 2)));
      if ((i % 10) == 9) wait_idle("random");
    end
    wait_idle("random_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
